// File: rtl/mem_pkg.sv
// Shared memory-side types: maskmode encodings and the buffered store entry.
package mem_pkg;

  localparam int unsigned MEM_DW = 32;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef struct packed {
    logic [MEM_DW-1:0] addr;
    logic [MEM_DW-1:0] data;
    logic [1:0]        maskmode;
  } sb_entry_t;

  // Reserved encoding 11 behaves as a full word.
  function automatic logic [1:0] norm_mask(input logic [1:0] m);
    return (m == 2'b11) ? MASK_WORD : m;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Parallel word-address compare of a load against all valid entries;
// reports the youngest (closest to tail) matching entry.
module store_buffer_match
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  sb_entry_t [DEPTH-1:0]         entries,
  input  logic [DEPTH-1:0]              valid,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [DATA_WIDTH-1:0]         ld_addr,
  output logic                          match_c,
  output logic                          word_c,
  output logic [DATA_WIDTH-1:0]         data_c
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [MEM_DW-1:0] la_c;
  assign la_c = MEM_DW'(ld_addr);

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    match_c = 1'b0;
    word_c  = 1'b0;
    data_c  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (valid[head + PW'(k)] &&
          (((entries[head + PW'(k)].addr ^ la_c) & ~MEM_DW'(3)) == '0)) begin
        match_c = 1'b1;
        word_c  = (entries[head + PW'(k)].maskmode == MASK_WORD);
        data_c  = DATA_WIDTH'(entries[head + PW'(k)].data);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores drained to data memory, with load conflict checks.
// Define STORE_BUFFER_FWD_EN to forward matching word stores to loads instead of stalling.
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [DATA_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [1:0]            st_maskmode,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  output logic                  ld_hit,
  output logic [DATA_WIDTH-1:0] ld_fwd_data,
  output logic                  ld_stall,
  output logic                  mem_write,
  output logic [1:0]            mem_maskmode,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_busy,
  output logic                  sb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  empty_c, push_c, pop_c;
  logic                  m_match, m_word;
  logic [DATA_WIDTH-1:0] m_data;

  assign empty_c  = (cnt_q == '0);
  assign st_ready = (cnt_q < CW'(DEPTH));
  assign push_c   = st_valid && st_ready;
  assign pop_c    = !empty_c && !mem_busy;
  assign sb_empty = empty_c;

  // Memory fields read zero while empty so stale entries never leak out.
  assign mem_write      = pop_c;
  assign mem_maskmode   = empty_c ? MASK_BYTE : ent_q[head_q].maskmode;
  assign mem_address    = empty_c ? '0 : DATA_WIDTH'(ent_q[head_q].addr);
  assign mem_write_data = empty_c ? '0 : DATA_WIDTH'(ent_q[head_q].data);

  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + CW'(push_c) - CW'(pop_c);
    if (push_c) begin
      ent_d[tail_q] = '{addr: MEM_DW'(st_addr), data: MEM_DW'(st_data),
                        maskmode: norm_mask(st_maskmode)};
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
    if (pop_c) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload needs no reset; validity alone qualifies it.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  store_buffer_match #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_match (
    .entries (ent_q),
    .valid   (vld_q),
    .head    (head_q),
    .ld_addr (ld_addr),
    .match_c (m_match),
    .word_c  (m_word),
    .data_c  (m_data)
  );

`ifdef STORE_BUFFER_FWD_EN
  assign ld_hit      = ld_valid && m_match && m_word;
  assign ld_stall    = ld_valid && m_match && !m_word;
  assign ld_fwd_data = ld_hit ? m_data : '0;
`else
  logic unused_fwd;
  assign unused_fwd  = ^{m_word, m_data};
  assign ld_hit      = 1'b0;
  assign ld_stall    = ld_valid && m_match;
  assign ld_fwd_data = '0;
`endif

endmodule
